mmio_wr_queue: RTL
==================

MMIO_WR_QUEUE -- requirements
Module: mmio_wr_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning the number of entries; it must be a power of 2 and at least 2.
REQ-002 The module SHALL have parameter ADDR_W, default 16, meaning the MMIO address width.
REQ-003 The module SHALL have parameter DATA_W, default 64, meaning the MMIO data width.
REQ-004 The module SHALL have port clk, input, 1 bit: the clock.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port wr_valid, input, 1 bit: an MMIO write is presented this cycle (driven from the CCI-P c0 mmioWrValid).
REQ-007 The module SHALL have port wr_addr, input, ADDR_W bits: the MMIO write address.
REQ-008 The module SHALL have port wr_data, input, DATA_W bits: the MMIO write data.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the head entry is available.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-011 The module SHALL have port out_addr, output, ADDR_W bits: the head entry address.
REQ-012 The module SHALL have port out_data, output, DATA_W bits: the head entry data.
REQ-013 The module SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-014 The module SHALL have ports full and empty, output, 1 bit each: occupancy flags.
REQ-015 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a write has been dropped.
REQ-016 The module SHALL have port clr_overflow, input, 1 bit: synchronous clear of overflow.
REQ-017 The module SHALL have port drop_count, output, 16 bits: saturating count of dropped writes.

Function
REQ-018 The queue SHALL be a circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 The queue SHALL be first-word fall-through: out_valid = !empty, and out_addr/out_data show the head entry combinationally from storage.
REQ-020 A push SHALL occur when wr_valid=1 and (full=0, or a pop occurs in the same cycle).
REQ-021 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-022 A write accepted at edge N SHALL appear at out_valid after edge N when the queue was empty, giving 1-cycle latency.
REQ-023 count SHALL update as +1 on push only, -1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-024 full SHALL equal (count==DEPTH), and empty SHALL equal (count==0).
REQ-025 When the queue is empty, wr_valid and out_ready asserted together SHALL push only, because no pop is possible.
REQ-026 When the queue is full, wr_valid with a same-cycle pop SHALL be accepted, and count SHALL stay at DEPTH.
REQ-027 When the queue is full, wr_valid without a pop SHALL drop the write, leave storage, pointers and count unchanged, set overflow, and increment drop_count.
REQ-028 drop_count SHALL saturate at 16'hFFFF.
REQ-029 clr_overflow SHALL clear overflow and drop_count.
REQ-030 If a drop and clr_overflow occur in the same cycle, overflow SHALL end at 1 and drop_count SHALL end at 1, so the set wins.
REQ-031 Entries SHALL be output in strict arrival order, with address and data kept together as one entry.
REQ-032 out_addr/out_data SHALL be don't-care while out_valid=0; the bench does not check them then.

Reset
REQ-033 Asserting rst SHALL immediately force pointers=0, count=0, empty=1, full=0, out_valid=0, overflow=0, and drop_count=0.
REQ-034 The storage array SHALL NOT be reset.
REQ-035 Asserting rst mid-operation SHALL discard all queued entries; the first write after deassertion SHALL become the head.
REQ-036 No push or pop SHALL occur on the clk edge where rst is asserted.

Structure
REQ-037 A shared package afu_mmio_pkg SHALL hold the ADDR_W and DATA_W constants and the typedef t_mmio_wr_entry, a packed struct {addr, data}.
REQ-038 Storage SHALL be an array of t_mmio_wr_entry.
REQ-039 No sub-module SHALL be used; storage, pointers and counters are implemented inline in mmio_wr_queue.

Verification
REQ-040 The bench SHALL cover: push 3 writes (0x20/0xA, 0x22/0xB, 0x24/0xC) with out_ready=0, then raise out_ready -> popped in order A, B, C; count goes 3,2,1,0; empty=1.
REQ-041 The bench SHALL cover: push 8 writes, then a 9th with out_ready=0 -> full=1, overflow=1, drop_count=1, and the 9th entry is never output.
REQ-042 The bench SHALL cover: with the queue full, push and pop in the same cycle -> count stays 8, the new entry becomes the tail, and overflow stays 0.
REQ-043 The bench SHALL cover: 20 push/pop pairs across pointer wrap -> data matches the scoreboard and count never exceeds 1.
REQ-044 The bench SHALL cover: assert rst with 5 entries queued -> count=0 and out_valid=0 immediately; after deassertion, push 0x55 -> head data=0x55.
REQ-045 The bench SHALL cover: drop and clr_overflow in the same cycle -> overflow=1 and drop_count=1.

Source files
------------

// File: rtl/afu_mmio_pkg.sv
// afu_mmio_pkg
//   Shared MMIO definitions for the AFU write path.
//   MMIO_ADDR_W / MMIO_DATA_W : MMIO address and data widths.
//   t_mmio_wr_entry           : one queued MMIO write {addr, data}.
package afu_mmio_pkg;

  localparam int MMIO_ADDR_W = 16;
  localparam int MMIO_DATA_W = 64;

  typedef struct packed {
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] data;
  } t_mmio_wr_entry;

endpackage

// File: rtl/mmio_wr_queue.sv
// mmio_wr_queue
//   First-word fall-through queue for CCI-P MMIO writes. Writes that
//   arrive while the queue is full (and nothing pops) are dropped and
//   recorded in a sticky overflow flag and a saturating drop counter.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   wr_valid/addr/data      : MMIO write presented this cycle (no back-pressure)
//   out_valid/ready/addr/data : head entry, valid/ready handshake
//   count, full, empty      : occupancy
//   overflow, clr_overflow  : sticky drop flag and its synchronous clear
//   drop_count              : saturating count of dropped writes
//
// Handshake: an entry leaves the queue on a clk edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready, and the head
// stays stable until it is taken. The write side has no ready: a write
// either enters the queue or is counted as dropped.
module mmio_wr_queue
  import afu_mmio_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [15:0]              drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entries are stored in the shared package struct; the casts adapt the
  // port widths to the package widths (identical at the defaults).
  t_mmio_wr_entry mem [DEPTH];
  t_mmio_wr_entry wr_entry;
  t_mmio_wr_entry head_entry;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = !empty;

  // No transfer may happen on an edge where rst is high, including the
  // unreset storage write below.
  assign pop  = out_valid && out_ready && !rst;
  assign push = wr_valid && (!full || pop) && !rst;
  assign drop = wr_valid && full && !pop && !rst;

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = MMIO_ADDR_W'(wr_addr);
    wr_entry.data = MMIO_DATA_W'(wr_data);
  end

  assign head_entry = mem[rd_ptr];
  assign out_addr   = ADDR_W'(head_entry.addr);
  assign out_data   = DATA_W'(head_entry.data);

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // A drop in the same cycle as clr_overflow wins: the flag stays set and
  // the counter restarts at 1 rather than 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      if (drop) begin
        if (clr_overflow) begin
          drop_count <= 16'd1;
        end else if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end else if (clr_overflow) begin
        drop_count <= '0;
      end
    end
  end

endmodule
